camera_pixel_capture: RTL



---
 rtl/camera_pixel_capture.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/camera_pixel_capture.sv
// camera_pixel_capture
// Upstream stage of the treasure image processor. Samples the OV7670 parallel
// bus (RGB565, two bytes per pixel) in the CLK domain, packs each pixel into
// RGB323 ({R[2:0], G[1:0], B[2:0]}) and writes it to the frame buffer at the
// linear address Y*SCREEN_WIDTH + X. Also reports frame/line status.
//
// Ports:
//   CLK           system clock, at least 4x the camera PCLK frequency
//   RESET_N       asynchronous active-low reset
//   CAM_PCLK      camera pixel clock (asynchronous to CLK)
//   CAM_HREF      camera line-valid
//   CAM_VSYNC     camera frame sync, high between frames
//   CAM_DATA      camera data byte
//   W_EN          frame-buffer write strobe, one CLK cycle per stored pixel
//   WRITE_ADDRESS frame-buffer linear address
//   PIXEL_OUT     RGB323 pixel
//   FRAME_DONE    one-cycle pulse at the end of each captured frame
//   LINE_COUNT    lines completed in the current frame (saturates at SCREEN_HEIGHT)
module camera_pixel_capture #(
    parameter int SCREEN_WIDTH  = 176,
    parameter int SCREEN_HEIGHT = 144,
    parameter int ADDR_W        = 15
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              CAM_PCLK,
    input  logic              CAM_HREF,
    input  logic              CAM_VSYNC,
    input  logic [7:0]        CAM_DATA,
    output logic              W_EN,
    output logic [ADDR_W-1:0] WRITE_ADDRESS,
    output logic [7:0]        PIXEL_OUT,
    output logic              FRAME_DONE,
    output logic [7:0]        LINE_COUNT
);

    localparam int X_W = $clog2(SCREEN_WIDTH + 1);
    localparam logic [X_W-1:0]    X_MAX     = X_W'(SCREEN_WIDTH);
    localparam logic [7:0]        Y_MAX     = 8'(SCREEN_HEIGHT);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(SCREEN_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_WAIT_VS_LOW = 2'd1,
        ST_CAPTURE     = 2'd2
    } state_t;

    // RGB565 byte pair -> RGB323: top 3 bits of R, top 2 of G, top 3 of B.
    function automatic logic [7:0] pack_rgb323(input logic [7:0] hi, input logic [7:0] lo);
        return {hi[7:5], hi[2:1], lo[4:2]};
    endfunction

    state_t            state_r;
    state_t            state_next_s;
    logic [2:0]        pclk_sync_r;
    logic [2:0]        href_sync_r;
    logic [2:0]        vsync_sync_r;
    logic [7:0]        data_d1_r;
    logic [7:0]        data_d2_r;
    logic [7:0]        hi_byte_r;
    logic              phase_r;
    logic [X_W-1:0]    x_r;
    logic [7:0]        y_r;
    logic [ADDR_W-1:0] line_base_r;

    logic pclk_rise_s;
    logic href_s;
    logic href_fall_s;
    logic vsync_s;
    logic vs_rise_s;
    logic vs_fall_s;
    logic capture_s;
    logic clear_s;
    logic byte_take_s;
    logic line_end_s;
    logic frame_end_s;

    // Two-flop synchronizers plus a third stage for edge detection; data rides
    // the same two-stage delay so it lines up with the synchronized PCLK edge.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pclk_sync_r  <= 3'b000;
            href_sync_r  <= 3'b000;
            vsync_sync_r <= 3'b000;
            data_d1_r    <= 8'h00;
            data_d2_r    <= 8'h00;
        end else begin
            pclk_sync_r  <= {pclk_sync_r[1:0], CAM_PCLK};
            href_sync_r  <= {href_sync_r[1:0], CAM_HREF};
            vsync_sync_r <= {vsync_sync_r[1:0], CAM_VSYNC};
            data_d1_r    <= CAM_DATA;
            data_d2_r    <= data_d1_r;
        end
    end

    assign pclk_rise_s = pclk_sync_r[1] & ~pclk_sync_r[2];
    assign href_s      = href_sync_r[1];
    assign href_fall_s = href_sync_r[2] & ~href_sync_r[1];
    assign vsync_s     = vsync_sync_r[1];
    assign vs_rise_s   = vsync_sync_r[1] & ~vsync_sync_r[2];
    assign vs_fall_s   = vsync_sync_r[2] & ~vsync_sync_r[1];

    // FSM state register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; capture starts only after a full VSYNC high->low.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (vsync_s) state_next_s = ST_WAIT_VS_LOW;
                else         state_next_s = ST_IDLE;
            end
            ST_WAIT_VS_LOW: begin
                if (vs_fall_s) state_next_s = ST_CAPTURE;
                else           state_next_s = ST_WAIT_VS_LOW;
            end
            ST_CAPTURE: begin
                if (vs_rise_s) state_next_s = ST_WAIT_VS_LOW;
                else           state_next_s = ST_CAPTURE;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM output decode: outside CAPTURE the frame position is held cleared.
    always_comb begin
        capture_s = 1'b0;
        clear_s   = 1'b1;
        case (state_r)
            ST_CAPTURE: begin
                capture_s = 1'b1;
                clear_s   = 1'b0;
            end
            ST_IDLE, ST_WAIT_VS_LOW: begin
                capture_s = 1'b0;
                clear_s   = 1'b1;
            end
            default: begin
                capture_s = 1'b0;
                clear_s   = 1'b1;
            end
        endcase
    end

    // byte_take and line_end are exclusive: one needs HREF high, the other low.
    assign byte_take_s = capture_s & pclk_rise_s & href_s;
    assign line_end_s  = capture_s & href_fall_s;
    assign frame_end_s = capture_s & vs_rise_s;

    // Byte assembly, frame position tracking and registered write outputs.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            W_EN          <= 1'b0;
            WRITE_ADDRESS <= '0;
            PIXEL_OUT     <= 8'h00;
            FRAME_DONE    <= 1'b0;
            LINE_COUNT    <= 8'h00;
            hi_byte_r     <= 8'h00;
            phase_r       <= 1'b0;
            x_r           <= '0;
            y_r           <= 8'h00;
            line_base_r   <= '0;
        end else begin
            W_EN       <= 1'b0;
            FRAME_DONE <= frame_end_s;
            if (clear_s) begin
                phase_r     <= 1'b0;
                x_r         <= '0;
                y_r         <= 8'h00;
                line_base_r <= '0;
                LINE_COUNT  <= 8'h00;
            end else if (byte_take_s) begin
                phase_r <= ~phase_r;
                if (!phase_r) begin
                    hi_byte_r <= data_d2_r;
                end else if (x_r < X_MAX) begin
                    // X parks at SCREEN_WIDTH so overlong lines never wrap.
                    x_r <= x_r + X_W'(1);
                    if (y_r < Y_MAX) begin
                        W_EN          <= 1'b1;
                        WRITE_ADDRESS <= line_base_r + ADDR_W'(x_r);
                        PIXEL_OUT     <= pack_rgb323(hi_byte_r, data_d2_r);
                    end
                end
            end else if (line_end_s) begin
                // A trailing odd byte is dropped by clearing the phase.
                phase_r <= 1'b0;
                if (x_r != '0) begin
                    x_r <= '0;
                    if (y_r < Y_MAX) begin
                        y_r         <= y_r + 8'd1;
                        line_base_r <= line_base_r + LINE_STEP;
                    end
                    if (LINE_COUNT < Y_MAX) begin
                        LINE_COUNT <= LINE_COUNT + 8'd1;
                    end
                end
            end
        end
    end

endmodule
